// File: rtl/execute_x_pipe.sv
// Execute X pipeline: single-cycle ALU/shifter feeding a DEPTH-stage delay line
// with per-stage forwarding taps and an in-order writeback port at the last stage.
module execute_x_pipe #(
    parameter int         WIDTH   = 32,
    parameter int         DEPTH   = 4,
    parameter logic [1:0] UNIT_ID = 2'd1,
    localparam int        SHW     = $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             is_x_functionalunit,
    input  logic                   is_x_selalushift,
    input  logic                   is_x_selimregb,
    input  logic [2:0]             is_x_aluop,
    input  logic                   is_x_unsig,
    input  logic [1:0]             is_x_shiftop,
    input  logic [SHW-1:0]         is_x_shiftamt,
    input  logic [WIDTH-1:0]       is_x_rega,
    input  logic [WIDTH-1:0]       is_x_regb,
    input  logic [WIDTH-1:0]       is_x_imedext,
    input  logic [4:0]             is_x_regdest,
    input  logic                   is_x_writereg,
    input  logic                   is_x_writeov,
    input  logic                   x_flush,
    output logic                   x_wb_valid,
    output logic [4:0]             x_wb_regdest,
    output logic                   x_wb_writereg,
    output logic [WIDTH-1:0]       x_wb_wbvalue,
    output logic                   x_wb_ov,
    output logic [DEPTH-1:0]       x_fwd_valid,
    output logic [DEPTH-1:0]       x_fwd_writereg,
    output logic [5*DEPTH-1:0]     x_fwd_regdest,
    output logic [WIDTH*DEPTH-1:0] x_fwd_value,
    output logic [3:0]             x_inflight,
    output logic                   x_busy
);

    logic             accept;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] rec_value;
    logic             rec_writereg;
    logic             rec_ov_trap;

    logic             valid_reg    [DEPTH];
    logic [4:0]       regdest_reg  [DEPTH];
    logic             writereg_reg [DEPTH];
    logic [WIDTH-1:0] value_reg    [DEPTH];
    logic             ov_trap_reg  [DEPTH];

    assign accept = (is_x_functionalunit == UNIT_ID) & ~x_flush & ~reset;

    always_comb begin
        alu_b   = is_x_selimregb ? is_x_imedext : is_x_regb;
        sum     = is_x_rega + alu_b;
        diff    = is_x_rega - alu_b;
        slt_lt  = is_x_unsig ? (is_x_rega < alu_b) : ($signed(is_x_rega) < $signed(alu_b));
        alu_res = '0;
        alu_ov  = 1'b0;
        case (is_x_aluop)
            3'b000: begin
                alu_res = sum;
                alu_ov  = ~is_x_unsig & (is_x_rega[WIDTH-1] == alu_b[WIDTH-1])
                                      & (sum[WIDTH-1] != is_x_rega[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff;
                alu_ov  = ~is_x_unsig & (is_x_rega[WIDTH-1] != alu_b[WIDTH-1])
                                      & (diff[WIDTH-1] != is_x_rega[WIDTH-1]);
            end
            3'b010:  alu_res = is_x_rega & alu_b;
            3'b011:  alu_res = is_x_rega | alu_b;
            3'b100:  alu_res = is_x_rega ^ alu_b;
            3'b101:  alu_res = ~(is_x_rega | alu_b);
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
            default: alu_res = alu_b;
        endcase
    end

    // Rotate right: output bit i takes source bit (i + amt) mod WIDTH; WIDTH is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ror
            logic [SHW-1:0] src_idx;
            assign src_idx     = SHW'(gi) + is_x_shiftamt;
            assign ror_res[gi] = is_x_regb[src_idx];
        end
    endgenerate

    always_comb begin
        case (is_x_shiftop)
            2'b00:   shift_res = is_x_regb << is_x_shiftamt;
            2'b01:   shift_res = is_x_regb >> is_x_shiftamt;
            2'b10:   shift_res = $signed(is_x_regb) >>> is_x_shiftamt;
            default: shift_res = ror_res;
        endcase
    end

    // Overflow only suppresses the write when the op did not ask to write anyway.
    always_comb begin
        rec_value    = is_x_selalushift ? shift_res : alu_res;
        rec_writereg = is_x_writereg & (~alu_ov | is_x_writeov);
        rec_ov_trap  = alu_ov & ~is_x_writeov;
    end

    always_ff @(posedge clock) begin
        if (reset || x_flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_reg[k]    <= 1'b0;
                regdest_reg[k]  <= '0;
                writereg_reg[k] <= 1'b0;
                value_reg[k]    <= '0;
                ov_trap_reg[k]  <= 1'b0;
            end
        end else begin
            valid_reg[0]    <= accept;
            regdest_reg[0]  <= accept ? is_x_regdest : 5'd0;
            writereg_reg[0] <= accept & rec_writereg;
            value_reg[0]    <= accept ? rec_value : '0;
            ov_trap_reg[0]  <= accept & rec_ov_trap;
            for (int k = 1; k < DEPTH; k++) begin
                valid_reg[k]    <= valid_reg[k-1];
                regdest_reg[k]  <= regdest_reg[k-1];
                writereg_reg[k] <= writereg_reg[k-1];
                value_reg[k]    <= value_reg[k-1];
                ov_trap_reg[k]  <= ov_trap_reg[k-1];
            end
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign x_fwd_valid[gi]                   = valid_reg[gi];
            assign x_fwd_writereg[gi]                = writereg_reg[gi];
            assign x_fwd_regdest[gi*5 +: 5]          = regdest_reg[gi];
            assign x_fwd_value[gi*WIDTH +: WIDTH]    = value_reg[gi];
        end
    endgenerate

    always_comb begin
        x_inflight = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            x_inflight = x_inflight + 4'(valid_reg[k]);
        end
    end

    assign x_busy        = (x_inflight != 4'd0);
    assign x_wb_valid    = valid_reg[DEPTH-1];
    assign x_wb_regdest  = regdest_reg[DEPTH-1];
    assign x_wb_writereg = writereg_reg[DEPTH-1];
    assign x_wb_wbvalue  = value_reg[DEPTH-1];
    assign x_wb_ov       = ov_trap_reg[DEPTH-1];

endmodule

// File: tb/tb_execute_x_pipe.sv
// Directed bench for execute_x_pipe: expected writebacks are queued at issue
// with their due cycle and checked against the writeback port every cycle.
module tb_execute_x_pipe;

    localparam int W = 32;
    localparam int D = 4;

    typedef logic [127:0] w_t;
    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic        ov;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    is_x_functionalunit;
    logic          is_x_selalushift;
    logic          is_x_selimregb;
    logic [2:0]    is_x_aluop;
    logic          is_x_unsig;
    logic [1:0]    is_x_shiftop;
    logic [4:0]    is_x_shiftamt;
    logic [W-1:0]  is_x_rega;
    logic [W-1:0]  is_x_regb;
    logic [W-1:0]  is_x_imedext;
    logic [4:0]    is_x_regdest;
    logic          is_x_writereg;
    logic          is_x_writeov;
    logic          x_flush;
    logic          x_wb_valid;
    logic [4:0]    x_wb_regdest;
    logic          x_wb_writereg;
    logic [W-1:0]  x_wb_wbvalue;
    logic          x_wb_ov;
    logic [D-1:0]  x_fwd_valid;
    logic [D-1:0]  x_fwd_writereg;
    logic [5*D-1:0] x_fwd_regdest;
    logic [W*D-1:0] x_fwd_value;
    logic [3:0]    x_inflight;
    logic          x_busy;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    exp_t q[$];

    execute_x_pipe #(.WIDTH(W), .DEPTH(D), .UNIT_ID(2'd1)) dut (
        .clock(clock), .reset(reset),
        .is_x_functionalunit(is_x_functionalunit), .is_x_selalushift(is_x_selalushift),
        .is_x_selimregb(is_x_selimregb), .is_x_aluop(is_x_aluop), .is_x_unsig(is_x_unsig),
        .is_x_shiftop(is_x_shiftop), .is_x_shiftamt(is_x_shiftamt),
        .is_x_rega(is_x_rega), .is_x_regb(is_x_regb), .is_x_imedext(is_x_imedext),
        .is_x_regdest(is_x_regdest), .is_x_writereg(is_x_writereg), .is_x_writeov(is_x_writeov),
        .x_flush(x_flush),
        .x_wb_valid(x_wb_valid), .x_wb_regdest(x_wb_regdest), .x_wb_writereg(x_wb_writereg),
        .x_wb_wbvalue(x_wb_wbvalue), .x_wb_ov(x_wb_ov),
        .x_fwd_valid(x_fwd_valid), .x_fwd_writereg(x_fwd_writereg),
        .x_fwd_regdest(x_fwd_regdest), .x_fwd_value(x_fwd_value),
        .x_inflight(x_inflight), .x_busy(x_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic set_idle();
        is_x_functionalunit = 2'd0; is_x_selalushift = 1'b0; is_x_selimregb = 1'b0;
        is_x_aluop = 3'd0; is_x_unsig = 1'b0; is_x_shiftop = 2'd0; is_x_shiftamt = 5'd0;
        is_x_rega = '0; is_x_regb = '0; is_x_imedext = '0; is_x_regdest = 5'd0;
        is_x_writereg = 1'b0; is_x_writeov = 1'b0;
    endtask

    // One clock edge, then compare the writeback port with the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        if (reset || x_flush) q.delete();
        #1;
        cycle++;
        if (q.size() > 0 && q[0].due == cycle) begin
            e = q.pop_front();
            chk("wb_valid", w_t'(x_wb_valid), w_t'(1'b1));
            chk("wb_regdest", w_t'(x_wb_regdest), w_t'(e.rd));
            chk("wb_writereg", w_t'(x_wb_writereg), w_t'(e.wr));
            chk("wb_value", w_t'(x_wb_wbvalue), w_t'(e.val));
            chk("wb_ov", w_t'(x_wb_ov), w_t'(e.ov));
            $display("cycle %0d: writeback rd=%0d value=%h wr=%0d ov=%0d",
                     cycle, x_wb_regdest, x_wb_wbvalue, x_wb_writereg, x_wb_ov);
        end else begin
            chk("wb_idle", w_t'(x_wb_valid), w_t'(1'b0));
        end
    endtask

    task automatic issue(input logic [1:0] fu, input logic sel_shift, input logic selim,
                         input logic [2:0] aluop, input logic unsig, input logic [1:0] sop,
                         input logic [4:0] amt, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rd, input logic wr,
                         input logic wov, input logic [31:0] exp_val, input logic exp_wr,
                         input logic exp_ov);
        exp_t e;
        is_x_functionalunit = fu; is_x_selalushift = sel_shift; is_x_selimregb = selim;
        is_x_aluop = aluop; is_x_unsig = unsig; is_x_shiftop = sop; is_x_shiftamt = amt;
        is_x_rega = a; is_x_regb = b; is_x_imedext = imm; is_x_regdest = rd;
        is_x_writereg = wr; is_x_writeov = wov;
        if (fu == 2'd1 && !x_flush && !reset) begin
            e.due = cycle + D; e.rd = rd; e.wr = exp_wr; e.val = exp_val; e.ov = exp_ov;
            q.push_back(e);
        end
        tick();
        set_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_valid"}, w_t'(x_wb_valid), w_t'(0));
        chk({tag, "_wb_regdest"}, w_t'(x_wb_regdest), w_t'(0));
        chk({tag, "_wb_writereg"}, w_t'(x_wb_writereg), w_t'(0));
        chk({tag, "_wb_value"}, w_t'(x_wb_wbvalue), w_t'(0));
        chk({tag, "_wb_ov"}, w_t'(x_wb_ov), w_t'(0));
        chk({tag, "_fwd_valid"}, w_t'(x_fwd_valid), w_t'(0));
        chk({tag, "_fwd_writereg"}, w_t'(x_fwd_writereg), w_t'(0));
        chk({tag, "_fwd_regdest"}, w_t'(x_fwd_regdest), w_t'(0));
        chk({tag, "_fwd_value"}, w_t'(x_fwd_value), w_t'(0));
        chk({tag, "_inflight"}, w_t'(x_inflight), w_t'(0));
        chk({tag, "_busy"}, w_t'(x_busy), w_t'(0));
    endtask

    initial begin
        reset = 1'b1; x_flush = 1'b0;
        set_idle();
        idle(2);
        reset = 1'b0;
        chk_all_zero("reset");

        // ADD 5 + 7 -> 12, visible in forwarding slot 0 right after accept
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd5, 32'd7, 32'd0, 5'd3, 1, 0, 32'd12, 1, 0);
        chk("fwd0_value", w_t'(x_fwd_value[31:0]), w_t'(32'd12));
        chk("fwd_valid_one", w_t'(x_fwd_valid), w_t'(4'b0001));
        chk("inflight_one", w_t'(x_inflight), w_t'(4'd1));
        idle(4);

        // Signed overflow, with and without write-on-overflow
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5, 1, 0, 32'h8000_0000, 0, 1);
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd6, 1, 1, 32'h8000_0000, 1, 0);
        // Unsigned add never traps
        issue(2'd1, 0, 0, 3'b000, 1, 2'b00, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd7, 1, 0, 32'h8000_0000, 1, 0);
        // Shifter cases
        issue(2'd1, 1, 0, 3'b000, 0, 2'b10, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 5'd8, 1, 0, 32'hF800_0000, 1, 0);
        issue(2'd1, 1, 0, 3'b000, 0, 2'b11, 5'd1, 32'd0, 32'h0000_0001, 32'd0, 5'd9, 1, 0, 32'h8000_0000, 1, 0);
        issue(2'd1, 1, 0, 3'b000, 0, 2'b00, 5'd0, 32'd0, 32'h0000_1234, 32'd0, 5'd10, 1, 0, 32'h0000_1234, 1, 0);
        issue(2'd1, 1, 0, 3'b000, 0, 2'b01, 5'd31, 32'd0, 32'h8000_0000, 32'd0, 5'd11, 1, 0, 32'h0000_0001, 1, 0);
        // SLT unsigned and signed
        issue(2'd1, 0, 0, 3'b110, 1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd12, 1, 0, 32'd0, 1, 0);
        issue(2'd1, 0, 0, 3'b110, 0, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd13, 1, 0, 32'd1, 1, 0);
        // SUB with immediate B, SUB overflow, XOR, NOR, pass B
        issue(2'd1, 0, 1, 3'b001, 0, 2'b00, 5'd0, 32'd10, 32'd100, 32'd3, 5'd14, 1, 0, 32'd7, 1, 0);
        issue(2'd1, 0, 0, 3'b001, 0, 2'b00, 5'd0, 32'h8000_0000, 32'd1, 32'd0, 5'd15, 1, 0, 32'h7FFF_FFFF, 0, 1);
        issue(2'd1, 0, 0, 3'b100, 0, 2'b00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 5'd16, 1, 0, 32'h0FF0_0FF0, 1, 0);
        issue(2'd1, 0, 0, 3'b101, 0, 2'b00, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'd0, 5'd17, 0, 0, 32'hFFFF_FF00, 0, 0);
        issue(2'd1, 0, 1, 3'b111, 0, 2'b00, 5'd0, 32'd9, 32'd1, 32'hABCD_0123, 5'd18, 1, 0, 32'hABCD_0123, 1, 0);
        idle(5);

        // Four back-to-back ops: full pipe, slot 0 youngest
        for (int i = 1; i <= 4; i++)
            issue(2'd1, 0, 0, 3'b011, 0, 2'b00, 5'd0, 32'd0, 32'(i * 16), 32'd0, 5'(i), 1, 0, 32'(i * 16), 1, 0);
        chk("inflight_full", w_t'(x_inflight), w_t'(4'd4));
        chk("fwd_regdest_full", w_t'(x_fwd_regdest), w_t'({5'd1, 5'd2, 5'd3, 5'd4}));
        chk("busy_full", w_t'(x_busy), w_t'(1'b1));
        idle(5);

        // Flush with a third op presented: nothing writes back
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd1, 32'd1, 32'd0, 5'd20, 1, 0, 32'd2, 1, 0);
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd2, 32'd2, 32'd0, 5'd21, 1, 0, 32'd4, 1, 0);
        x_flush = 1'b1;
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd3, 32'd3, 32'd0, 5'd22, 1, 0, 32'd6, 1, 0);
        x_flush = 1'b0;
        chk("flush_inflight", w_t'(x_inflight), w_t'(4'd0));
        chk("flush_busy", w_t'(x_busy), w_t'(1'b0));
        idle(5);

        // Foreign unit code: bubble
        issue(2'd2, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd1, 32'd1, 32'd0, 5'd23, 1, 0, 32'd2, 1, 0);
        chk("foreign_inflight", w_t'(x_inflight), w_t'(4'd0));
        idle(4);

        // Reset with three ops in flight (and one presented)
        for (int i = 0; i < 3; i++)
            issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'(i), 32'd1, 32'd0, 5'(24 + i), 1, 0, 32'(i + 1), 1, 0);
        chk("pre_reset_inflight", w_t'(x_inflight), w_t'(4'd3));
        reset = 1'b1;
        issue(2'd1, 0, 0, 3'b000, 0, 2'b00, 5'd0, 32'd5, 32'd5, 32'd0, 5'd30, 1, 0, 32'd10, 1, 0);
        reset = 1'b0;
        chk_all_zero("midreset");
        idle(5);
        chk("drain_queue_empty", w_t'(q.size()), w_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
